semi_auto_sequencer: RTL and testbench

//  Parametrised successor to the semi-auto command decoder. Queues driver commands
//  (left/right/straight/back) and executes each one as a timed manoeuvre: rotate, then drive forward.

---
 rtl/semi_auto_sequencer_if.sv | 34 +++
 rtl/semi_auto_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_semi_auto_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/semi_auto_sequencer_if.sv
// Driver command / motor status bundle of the semi-auto sequencer.
//   master : front-end side (drives enable and the one-cycle command pulses)
//   slave  : sequencer side (drives motor controls, heading and queue status)
//   enable, turn_left, turn_right, go_straight, turn_back  master -> slave
//   move_forward, rotate, clockwise, cur[1:0], busy,
//   q_count[QW-1:0], cmd_drop                              slave -> master
interface semi_auto_sequencer_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned QW = $clog2(DEPTH + 1);

   logic          enable;
   logic          turn_left;
   logic          turn_right;
   logic          go_straight;
   logic          turn_back;
   logic          move_forward;
   logic          rotate;
   logic          clockwise;
   logic [1:0]    cur;
   logic          busy;
   logic [QW-1:0] q_count;
   logic          cmd_drop;

   modport master (
      output enable, turn_left, turn_right, go_straight, turn_back,
      input  move_forward, rotate, clockwise, cur, busy, q_count, cmd_drop
   );

   modport slave (
      input  enable, turn_left, turn_right, go_straight, turn_back,
      output move_forward, rotate, clockwise, cur, busy, q_count, cmd_drop
   );
endinterface

// File: rtl/semi_auto_sequencer.sv
// Queues driver commands and runs each as a timed manoeuvre (rotate, then
// drive forward) while tracking the absolute heading.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   io_bus     : slave side of semi_auto_sequencer_if (commands in, motor
//                controls / heading / queue status out, all registered)
module semi_auto_sequencer #(
   parameter int unsigned TURN_CYCLES = 50_000_000,
   parameter int unsigned FWD_CYCLES  = 100_000_000,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   semi_auto_sequencer_if.slave  io_bus
);
   localparam int unsigned QW = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] BACK_LAST = CNT_W'(2 * TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] FWD_LAST  = CNT_W'(FWD_CYCLES - 1);

   localparam logic [1:0] CMD_S = 2'b00;
   localparam logic [1:0] CMD_L = 2'b01;
   localparam logic [1:0] CMD_R = 2'b10;
   localparam logic [1:0] CMD_B = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_TURN = 2'd2,
      ST_FWD  = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_timer, w_timer_nxt;
   logic [1:0]       r_dir,   w_dir_nxt;
   logic [1:0]       r_cur,   w_cur_nxt;
   logic [1:0]       r_mem [DEPTH];
   logic [1:0]       w_mem_nxt [DEPTH];
   logic [QW-1:0]    r_count, w_count_nxt, w_wr_idx;
   logic             w_pop, w_push, w_full, w_cmd_req, w_drop;
   logic [1:0]       w_cmd;
   logic             r_move, r_rotate, r_cw, r_busy, r_drop;
   logic             w_move_nxt, w_rotate_nxt, w_cw_nxt, w_busy_nxt;

   // Heading change applied when a turn completes (2-bit wrap).
   function automatic logic [1:0] heading_step(input logic [1:0] dir);
      case (dir)
         CMD_L:   return 2'd3;
         CMD_R:   return 2'd1;
         CMD_B:   return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   // Command pick: left > right > straight > back; losers vanish silently.
   always_comb begin
      w_cmd     = CMD_S;
      w_cmd_req = 1'b0;
      if (io_bus.enable && r_state != ST_IDLE) begin
         w_cmd_req = 1'b1;
         if (io_bus.turn_left)        w_cmd = CMD_L;
         else if (io_bus.turn_right)  w_cmd = CMD_R;
         else if (io_bus.go_straight) w_cmd = CMD_S;
         else if (io_bus.turn_back)   w_cmd = CMD_B;
         else                         w_cmd_req = 1'b0;
      end
   end

   // Next-state logic; the head is popped only from WAIT, so a fresh
   // command always spends one cycle in the queue.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_dir_nxt   = r_dir;
      w_cur_nxt   = r_cur;
      w_pop       = 1'b0;
      if (!io_bus.enable) begin
         w_state_nxt = ST_IDLE;
         w_timer_nxt = '0;
      end else begin
         case (r_state)
            ST_WAIT: begin
               if (r_count != '0) begin
                  w_pop     = 1'b1;
                  w_dir_nxt = r_mem[0];
                  case (r_mem[0])
                     CMD_S: begin
                        w_state_nxt = ST_FWD;
                        w_timer_nxt = FWD_LAST;
                     end
                     CMD_B: begin
                        w_state_nxt = ST_TURN;
                        w_timer_nxt = BACK_LAST;
                     end
                     default: begin
                        w_state_nxt = ST_TURN;
                        w_timer_nxt = TURN_LAST;
                     end
                  endcase
               end
            end
            ST_TURN: begin
               if (r_timer == '0) begin
                  w_cur_nxt   = r_cur + heading_step(r_dir);
                  w_state_nxt = ST_FWD;
                  w_timer_nxt = FWD_LAST;
               end else begin
                  w_timer_nxt = r_timer - CNT_W'(1);
               end
            end
            ST_FWD: begin
               if (r_timer == '0) w_state_nxt = ST_WAIT;
               else               w_timer_nxt = r_timer - CNT_W'(1);
            end
            default: w_state_nxt = ST_WAIT;
         endcase
      end
   end

   // Shift-register queue: head at index 0; a full queue still accepts a
   // push when the head leaves in the same cycle.
   always_comb begin
      w_full    = (r_count == QW'(DEPTH));
      w_push    = w_cmd_req && (!w_full || w_pop);
      w_drop    = w_cmd_req && w_full && !w_pop;
      w_wr_idx  = w_pop ? (r_count - QW'(1)) : r_count;
      w_mem_nxt = r_mem;
      if (w_pop) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) w_mem_nxt[i] = r_mem[i+1];
      end
      if (w_push) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_wr_idx == QW'(i)) w_mem_nxt[i] = w_cmd;
         end
      end
      if (!io_bus.enable) w_count_nxt = '0;
      else                w_count_nxt = r_count + QW'(w_push) - QW'(w_pop);
   end

   // Output decode from the next state so the registered outputs line up
   // with the state they describe.
   always_comb begin
      w_move_nxt   = 1'b0;
      w_rotate_nxt = 1'b0;
      w_cw_nxt     = 1'b0;
      case (w_state_nxt)
         ST_TURN: begin
            w_rotate_nxt = 1'b1;
            w_cw_nxt     = (w_dir_nxt != CMD_L);
         end
         ST_FWD:  w_move_nxt = 1'b1;
         default: ;
      endcase
      w_busy_nxt = (w_state_nxt == ST_TURN) || (w_state_nxt == ST_FWD) ||
                   (w_count_nxt != '0);
   end

   // State register with manoeuvre timer, latched direction and heading.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_dir   <= CMD_S;
         r_cur   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_dir   <= w_dir_nxt;
         r_cur   <= w_cur_nxt;
      end
   end

   // Queue storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem   <= '{default: 2'b00};
         r_count <= '0;
      end else begin
         r_mem   <= w_mem_nxt;
         r_count <= w_count_nxt;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_move   <= 1'b0;
         r_rotate <= 1'b0;
         r_cw     <= 1'b0;
         r_busy   <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         r_move   <= w_move_nxt;
         r_rotate <= w_rotate_nxt;
         r_cw     <= w_cw_nxt;
         r_busy   <= w_busy_nxt;
         r_drop   <= w_drop;
      end
   end

   assign io_bus.move_forward = r_move;
   assign io_bus.rotate       = r_rotate;
   assign io_bus.clockwise    = r_cw;
   assign io_bus.cur          = r_cur;
   assign io_bus.busy         = r_busy;
   assign io_bus.q_count      = r_count;
   assign io_bus.cmd_drop     = r_drop;
endmodule

// File: tb/tb_semi_auto_sequencer.sv
module tb_semi_auto_sequencer;
   localparam int TURN  = 4;
   localparam int FWD   = 3;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   localparam logic [3:0] P_L = 4'b1000;
   localparam logic [3:0] P_R = 4'b0100;
   localparam logic [3:0] P_S = 4'b0010;
   localparam logic [3:0] P_B = 4'b0001;
   localparam logic [3:0] P_0 = 4'b0000;

   logic clk;
   logic rst_n;

   semi_auto_sequencer_if #(.DEPTH(DEPTH)) bus ();

   semi_auto_sequencer #(
      .TURN_CYCLES(TURN), .FWD_CYCLES(FWD), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .io_bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       mv;
      logic       rot;
      logic       cw;
      logic [1:0] cur;
   } frame_t;

   frame_t     plan[$];     // per-cycle outputs of the manoeuvre in progress
   logic [1:0] q[$];        // pending commands: 0 S, 1 L, 2 R, 3 B
   bit         m_active;
   logic [1:0] m_cur;
   bit         m_drop;

   function automatic void model_reset();
      plan.delete();
      q.delete();
      m_active = 0;
      m_cur    = 2'd0;
      m_drop   = 0;
   endfunction

   function automatic void model_build(input logic [1:0] c);
      int         nturn;
      bit         cw;
      logic [1:0] nh;
      nturn = (c == 2'd0) ? 0 : (c == 2'd3) ? 2 * TURN : TURN;
      cw    = (c == 2'd2) || (c == 2'd3);
      nh    = (c == 2'd1) ? m_cur - 2'd1 : (c == 2'd2) ? m_cur + 2'd1 :
              (c == 2'd3) ? m_cur + 2'd2 : m_cur;
      for (int k = 0; k < nturn; k++) plan.push_back('{1'b0, 1'b1, cw, m_cur});
      for (int k = 0; k < FWD; k++)   plan.push_back('{1'b1, 1'b0, 1'b0, nh});
   endfunction

   function automatic void model_edge(input bit en, input logic [3:0] p);
      logic [1:0] c;
      m_drop = 0;
      if (!en) begin
         m_active = 0;
         q.delete();
         plan.delete();
      end else if (!m_active) begin
         m_active = 1;
      end else begin
         if (plan.size() != 0) void'(plan.pop_front());
         else if (q.size() != 0) model_build(q.pop_front());
         if (p != 4'b0000) begin
            c = p[3] ? 2'd1 : p[2] ? 2'd2 : p[1] ? 2'd0 : 2'd3;
            if (q.size() < DEPTH) q.push_back(c);
            else m_drop = 1;
         end
         if (plan.size() != 0) m_cur = plan[0].cur;
      end
   endfunction

   function automatic logic [31:0] pack_obs(input bit mv, input bit rot, input bit cw,
                                            input logic [1:0] cur, input int qc,
                                            input bit busy, input bit drop);
      return 32'({mv, rot, cw, cur, 3'(qc), busy, drop});
   endfunction

   function automatic logic [31:0] model_obs();
      frame_t f;
      f = (plan.size() != 0) ? plan[0] : '{1'b0, 1'b0, 1'b0, m_cur};
      return pack_obs(f.mv, f.rot, f.cw, m_cur, q.size(),
                      (plan.size() != 0) || (q.size() != 0), m_drop);
   endfunction

   function automatic logic [31:0] dut_obs();
      return 32'({bus.move_forward, bus.rotate, bus.clockwise, bus.cur,
                  bus.q_count, bus.busy, bus.cmd_drop});
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model on the edge, settle.
   task automatic cycle(input bit en, input logic [3:0] p);
      bus.enable      = en;
      bus.turn_left   = p[3];
      bus.turn_right  = p[2];
      bus.go_straight = p[1];
      bus.turn_back   = p[0];
      @(posedge clk);
      model_edge(en, p);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int          rep;
      logic [3:0]  p;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int rep, input logic [3:0] p, input bit mv, input bit rot,
                               input bit cw, input logic [1:0] cur, input int qc, input bit busy);
      vec_t v;
      v.rep = rep;
      v.p   = p;
      v.exp = pack_obs(mv, rot, cw, cur, qc, busy, 1'b0);
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [1:0] cur_before;
      int         drops;
      logic [3:0] rp;
      bit         ren;

      rst_n           = 1'b0;
      bus.enable      = 1'b0;
      bus.turn_left   = 1'b0;
      bus.turn_right  = 1'b0;
      bus.go_straight = 1'b0;
      bus.turn_back   = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset", dut_obs(), 32'd0);
      #2 rst_n = 1'b1;

      // right turn, left to wrap, left again, U-turn, then simultaneous pulses
      tbl.push_back(mk(1, P_0,         0, 0, 0, 2'd0, 0, 0));
      tbl.push_back(mk(1, P_R,         0, 0, 0, 2'd0, 1, 1));
      tbl.push_back(mk(4, P_0,         0, 1, 1, 2'd0, 0, 1));
      tbl.push_back(mk(3, P_0,         1, 0, 0, 2'd1, 0, 1));
      tbl.push_back(mk(1, P_0,         0, 0, 0, 2'd1, 0, 0));
      tbl.push_back(mk(1, P_L,         0, 0, 0, 2'd1, 1, 1));
      tbl.push_back(mk(4, P_0,         0, 1, 0, 2'd1, 0, 1));
      tbl.push_back(mk(3, P_0,         1, 0, 0, 2'd0, 0, 1));
      tbl.push_back(mk(1, P_0,         0, 0, 0, 2'd0, 0, 0));
      tbl.push_back(mk(1, P_L,         0, 0, 0, 2'd0, 1, 1));
      tbl.push_back(mk(4, P_0,         0, 1, 0, 2'd0, 0, 1));
      tbl.push_back(mk(3, P_0,         1, 0, 0, 2'd3, 0, 1));
      tbl.push_back(mk(1, P_0,         0, 0, 0, 2'd3, 0, 0));
      tbl.push_back(mk(1, P_B,         0, 0, 0, 2'd3, 1, 1));
      tbl.push_back(mk(8, P_0,         0, 1, 1, 2'd3, 0, 1));
      tbl.push_back(mk(3, P_0,         1, 0, 0, 2'd1, 0, 1));
      tbl.push_back(mk(1, P_0,         0, 0, 0, 2'd1, 0, 0));
      tbl.push_back(mk(1, P_L|P_R|P_S, 0, 0, 0, 2'd1, 1, 1));
      tbl.push_back(mk(4, P_0,         0, 1, 0, 2'd1, 0, 1));
      tbl.push_back(mk(3, P_0,         1, 0, 0, 2'd0, 0, 1));
      tbl.push_back(mk(1, P_0,         0, 0, 0, 2'd0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         for (int r = 0; r < tbl[i].rep; r++) begin
            cycle(1'b1, tbl[i].p);
            check($sformatf("tbl[%0d].%0d", i, r), dut_obs(), tbl[i].exp);
         end
      end

      // async reset mid-FWD with heading S
      cycle(1'b1, P_B);
      repeat (10) cycle(1'b1, P_0);
      check("t6_fwd_cur2", dut_obs(), pack_obs(1, 0, 0, 2'd2, 0, 1, 0));
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_rst", dut_obs(), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      check("t6_rst_held", dut_obs(), 32'd0);
      rst_n = 1'b1;
      cycle(1'b1, P_0);
      check("t6_wait", dut_obs(), model_obs());

      // six commands while busy: queue saturates, two drops, FIFO order
      drops = 0;
      cycle(1'b1, P_L);
      check("t3_first", dut_obs(), model_obs());
      cycle(1'b1, P_0);
      check("t3_pop", dut_obs(), model_obs());
      foreach (tbl[i]) ;
      begin
         logic [3:0] seq [6];
         seq = '{P_R, P_S, P_L, P_B, P_R, P_L};
         for (int i = 0; i < 6; i++) begin
            cycle(1'b1, seq[i]);
            drops += int'(bus.cmd_drop);
            check($sformatf("t3_push%0d", i), dut_obs(), model_obs());
            if (i >= 3) check($sformatf("t3_qc%0d", i), 32'(bus.q_count), 32'd4);
         end
      end
      for (int i = 0; i < 70; i++) begin
         cycle(1'b1, P_0);
         drops += int'(bus.cmd_drop);
         check("t3_drain", dut_obs(), model_obs());
      end
      check("t3_drops", 32'(drops), 32'd2);

      // enable dropped in the second turn cycle with two entries queued
      cur_before = m_cur;
      cycle(1'b1, P_L);
      cycle(1'b1, P_R);
      cycle(1'b1, P_S);
      check("t5_pre", dut_obs(), pack_obs(0, 1, 0, cur_before, 2, 1, 0));
      cycle(1'b0, P_0);
      check("t5_off", dut_obs(), pack_obs(0, 0, 0, cur_before, 0, 0, 0));
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, P_0);
         check($sformatf("t5_reen%0d", i), dut_obs(), pack_obs(0, 0, 0, cur_before, 0, 0, 0));
      end

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         ren = ($urandom_range(0, 99) >= 2);
         rp  = ($urandom_range(0, 99) < 25) ? 4'($urandom_range(1, 15)) : 4'b0000;
         cycle(ren, rp);
         check("rand", dut_obs(), model_obs());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
